// File: rtl/rf_write_queue_if.sv
// Bundles the writeback request handshake, array write port, bypass lookups and occupancy
// of the register-file write queue. The master side is the writeback/decode logic, the slave side is the queue.
interface rf_write_queue_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  // enq_valid/enq_ready: a request transfers on a rising edge where both are high;
  // enq_ready never depends on enq_valid or on the same cycle's drain.
  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic              hold;
  logic [NUM_REGS-1:0] wr_en_onehot;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;
  logic [ADDR_W:0]   count;

  modport master (
    output enq_valid, enq_addr, enq_data, hold, rd_addr1, rd_addr2,
    input  enq_ready, wr_en_onehot, wr_data, byp_hit1, byp_data1, byp_hit2, byp_data2, count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, hold, rd_addr1, rd_addr2,
    output enq_ready, wr_en_onehot, wr_data, byp_hit1, byp_data1, byp_hit2, byp_data2, count
  );
endinterface

// File: rtl/rf_write_queue.sv
// Register-file write queue: buffers writeback requests, drains one per cycle into a one-hot
// write port, and offers youngest-first bypass lookup over pending writes.
module rf_write_queue #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  rf_write_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   ent_addr_q [DEPTH];
  logic [DATA_W-1:0]   ent_data_q [DEPTH];
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic enq_ready, push, pop;
  logic [ADDR_W-1:0] rd_addr [2];
  logic              hit     [2];
  logic [DATA_W-1:0] hit_data[2];

  // Writes to register 0 complete the handshake but are discarded.
  always_comb begin
    enq_ready = (count_q != FULL_CNT);
    push      = bus.enq_valid && enq_ready && (bus.enq_addr != '0);
    pop       = (count_q != '0) && !bus.hold;
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop) begin
      head_d                      = head_q + PTR_W'(1);
      wr_en_d[ent_addr_q[head_q]] = 1'b1;
      wr_data_d                   = ent_data_q[head_q];
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      if (push) begin
        ent_addr_q[tail_q] <= bus.enq_addr;
        ent_data_q[tail_q] <= bus.enq_data;
      end
    end
  end

  // Oldest candidate first so that each younger match overrides: output stage, then head..tail-1.
  always_comb begin
    rd_addr[0] = bus.rd_addr1;
    rd_addr[1] = bus.rd_addr2;
    for (int p = 0; p < 2; p++) begin
      hit[p]      = 1'b0;
      hit_data[p] = '0;
      if (rd_addr[p] != '0) begin
        if (wr_en_q[rd_addr[p]]) begin
          hit[p]      = 1'b1;
          hit_data[p] = wr_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
          if ((CNT_W'(k) < count_q) && (ent_addr_q[head_q + PTR_W'(k)] == rd_addr[p])) begin
            hit[p]      = 1'b1;
            hit_data[p] = ent_data_q[head_q + PTR_W'(k)];
          end
        end
      end
    end
  end

  assign bus.enq_ready    = enq_ready;
  assign bus.wr_en_onehot = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.byp_hit1     = hit[0];
  assign bus.byp_data1    = hit_data[0];
  assign bus.byp_hit2     = hit[1];
  assign bus.byp_data2    = hit_data[1];
  assign bus.count        = count_q;

  a_ptr_count : assert property (@(posedge clk) disable iff (!rst)
    (PTR_W'(tail_q - head_q) == count_q[PTR_W-1:0]) && (count_q <= FULL_CNT));
  a_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(wr_en_q));
endmodule
